// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch and data requesters.
// Data wins arbitration until STARVE_LIMIT data grants in a row have held off a waiting fetch.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  output logic        IStall,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic        DStall,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic        MemErr
);

  // state | meaning
  // IDLE  | no access outstanding; arbitrate between IReq and DReq
  // IBUS  | fetch access presented on the memory port
  // DBUS  | data access presented on the memory port
  typedef enum logic [1:0] {IDLE, IBUS, DBUS} arbState;

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arbState       state;
  logic [SW-1:0] scnt;
  logic [WW-1:0] wcnt;
  logic [31:0]   irq;
  logic [31:0]   drq;
  logic          starved;
  logic          dGrant;
  logic          iGrant;
  logic          busy;
  logic          timeoutHit;
  logic          done;

  assign starved    = IReq && (scnt == SLIM);
  assign dGrant     = (state == IDLE) && DReq && !starved;
  assign iGrant     = (state == IDLE) && IReq && !dGrant;
  assign busy       = (state != IDLE);
  assign timeoutHit = (TIMEOUT != 0) && busy && !MemAck && (wcnt == WLAST);
  assign done       = busy && (MemAck || timeoutHit);

  // A watchdog expiry completes the access with zero data and leaves the captured word alone.
  assign IReady = (state == IBUS) && done;
  assign DReady = (state == DBUS) && done;
  assign IRdata = IReady ? (timeoutHit ? 32'h0 : MemRdata) : irq;
  assign DRdata = DReady ? (timeoutHit ? 32'h0 : MemRdata) : drq;
  assign IStall = IReq && !IReady;
  assign DStall = DReq && !DReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= 32'h0;
      MemWdata <= 32'h0;
      MemErr   <= 1'b0;
      scnt     <= '0;
      wcnt     <= '0;
      irq      <= 32'h0;
      drq      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (dGrant) begin
            state    <= DBUS;
            MemReq   <= 1'b1;
            MemWe    <= DWe;
            MemAddr  <= DAddr;
            MemWdata <= DWdata;
            if (!IReq)             scnt <= '0;
            else if (scnt != SLIM) scnt <= scnt + 1'b1;
          end else if (iGrant) begin
            state   <= IBUS;
            MemReq  <= 1'b1;
            MemWe   <= 1'b0;
            MemAddr <= IAddr;
            scnt    <= '0;
          end
        end
        default: begin
          if (done) begin
            state  <= IDLE;
            MemReq <= 1'b0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
          if (timeoutHit) MemErr <= 1'b1;
          if (MemAck && state == IBUS) irq <= MemRdata;
          if (MemAck && state == DBUS && !MemWe) drq <= MemRdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios, then randomized traffic against a
// memory model and an arbitration rule checker.
module tb_mem_arbiter;

  localparam int SLIMIT = 4;
  localparam int TOUT   = 8;

  logic        clk;
  logic        reset;
  logic        IReq, DReq, DWe;
  logic [31:0] IAddr, DAddr, DWdata;
  logic [31:0] IRdata, DRdata;
  logic        IReady, IStall, DReady, DStall;
  logic        MemReq, MemWe, MemErr, MemAck;
  logic [31:0] MemAddr, MemWdata, MemRdata;

  logic        autoMem, autoAck, manAck, noise, chkArb;
  logic [31:0] autoRdata, manRdata;
  int          fixedWait;

  assign MemAck   = autoMem ? autoAck : manAck;
  assign MemRdata = autoMem ? autoRdata : manRdata;

  mem_arbiter #(.STARVE_LIMIT(SLIMIT), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady), .IStall(IStall),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DReady(DReady), .DStall(DStall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck), .MemErr(MemErr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {logic [31:0] data; logic we; logic to;} expT;
  typedef struct packed {logic [31:0] addr; logic we; logic [31:0] wdata;} memT;

  expT         iExp[$];
  expT         dExp[$];
  memT         iMem[$];
  memT         dMem[$];
  bit          grantLog[$];
  logic [31:0] refMem [logic [31:0]];
  logic [31:0] memArr [logic [31:0]];

  int   nCmp = 0;
  int   nBad = 0;
  logic lastIReq, lastDReq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    nCmp++;
    if (act !== want) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic expT mkExp(input logic [31:0] d, input logic we, input logic to);
    expT e;
    e.data = d; e.we = we; e.to = to;
    return e;
  endfunction

  function automatic memT mkMem(input logic [31:0] a, input logic we, input logic [31:0] wd);
    memT m;
    m.addr = a; m.we = we; m.wdata = wd;
    return m;
  endfunction

  // Contents of any memory word that has never been written.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetchOp(input logic [31:0] a);
    logic ok;
    iExp.push_back(mkExp(dflt(a), 1'b0, 1'b0));
    iMem.push_back(mkMem(a, 1'b0, 32'h0));
    IReq = 1'b1; IAddr = a;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = IReady;
    end
    check("IReady within budget", ok, 1);
    @(posedge clk); #1;
    IReq = 1'b0;
  endtask

  task automatic dataOp(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic ok;
    if (we) begin
      dExp.push_back(mkExp(32'h0, 1'b1, 1'b0));
      refMem[a] = wd;
    end else begin
      dExp.push_back(mkExp(refMem.exists(a) ? refMem[a] : dflt(a), 1'b0, 1'b0));
    end
    dMem.push_back(mkMem(a, we, wd));
    DReq = 1'b1; DWe = we; DAddr = a; DWdata = wd;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = DReady;
    end
    check("DReady within budget", ok, 1);
    @(posedge clk); #1;
    DReq = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a port completes, otherwise checks the held read data.
  logic [31:0] lastI, lastD;
  initial begin
    expT e;
    lastI = 32'h0; lastD = 32'h0;
    forever begin
      @(negedge clk);
      lastIReq = IReq;
      lastDReq = DReq;
      if (!reset) begin
        lastI = 32'h0;
        lastD = 32'h0;
      end else begin
        check("IStall", IStall, IReq & ~IReady);
        check("DStall", DStall, DReq & ~DReady);
        if (IReady) begin
          if (iExp.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL spurious IReady: IReady=1 with no fetch outstanding (t=%0t)", $time);
          end else begin
            e = iExp.pop_front();
            check("IRdata on IReady", IRdata, e.data);
            if (!e.to) lastI = e.data;
          end
        end else begin
          check("IRdata held", IRdata, lastI);
        end
        if (DReady) begin
          if (dExp.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL spurious DReady: DReady=1 with no data access outstanding (t=%0t)", $time);
          end else begin
            e = dExp.pop_front();
            if (!e.we) begin
              check("DRdata on DReady", DRdata, e.data);
              if (!e.to) lastD = e.data;
            end
          end
        end else begin
          check("DRdata held", DRdata, lastD);
        end
      end
    end
  end

  // Memory responder plus grant checker: consecutive data grants that hold off a waiting fetch
  // may not exceed SLIMIT, and when both ports wait data must win below that bound.
  initial begin
    int          left, run;
    logic [31:0] txAddr, txWdata;
    logic        txWe, inTxn, isD;
    memT         m;
    autoAck = 1'b0; autoRdata = 32'h0; inTxn = 1'b0; run = 0; left = 0;
    txAddr = 32'h0; txWdata = 32'h0; txWe = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!chkArb) run = 0;
      if (!MemReq) begin
        inTxn     = 1'b0;
        autoAck   = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        autoRdata = $urandom;
      end else begin
        if (!inTxn) begin
          inTxn   = 1'b1;
          left    = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
          txAddr  = MemAddr; txWe = MemWe; txWdata = MemWdata;
          if (chkArb) begin
            isD = MemAddr[29];
            grantLog.push_back(isD);
            if (isD) check("data grant had DReq", lastDReq, 1);
            else     check("fetch grant had IReq", lastIReq, 1);
            if (lastIReq && lastDReq) check("arbitration winner is data", isD, (run < SLIMIT) ? 1 : 0);
            run = (isD && lastIReq) ? run + 1 : 0;
            if (isD && dMem.size() != 0) begin
              m = dMem.pop_front();
              check("data grant MemAddr", MemAddr, m.addr);
              check("data grant MemWe", MemWe, m.we);
              if (m.we) check("data grant MemWdata", MemWdata, m.wdata);
            end else if (!isD && iMem.size() != 0) begin
              m = iMem.pop_front();
              check("fetch grant MemAddr", MemAddr, m.addr);
              check("fetch grant MemWe", MemWe, 0);
            end else begin
              nCmp++; nBad++;
              $display("FAIL unexpected grant: MemAddr=0x%08h, required no grant (t=%0t)", MemAddr, $time);
            end
          end
        end else if (chkArb) begin
          check("MemAddr held while busy", MemAddr, txAddr);
          check("MemWdata held while busy", MemWdata, txWdata);
          check("MemWe held while busy", MemWe, txWe);
        end
        if (left == 0) begin
          autoAck   = 1'b1;
          autoRdata = txWe ? $urandom : (memArr.exists(txAddr) ? memArr[txAddr] : dflt(txAddr));
          if (autoMem && txWe) memArr[txAddr] = txWdata;
        end else begin
          autoAck = 1'b0;
          left--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global time limit: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int       base, n;
    logic [9:0] got;
    reset = 1'b1; IReq = 1'b0; IAddr = 32'h0; DReq = 1'b0; DWe = 1'b0; DAddr = 32'h0; DWdata = 32'h0;
    manAck = 1'b0; manRdata = 32'h0; autoMem = 1'b0; noise = 1'b0; chkArb = 1'b0; fixedWait = 0;
    #1 reset = 1'b0;
    #2;
    check("reset MemReq", MemReq, 0);
    check("reset MemWe", MemWe, 0);
    check("reset MemAddr", MemAddr, 0);
    check("reset MemWdata", MemWdata, 0);
    check("reset MemErr", MemErr, 0);
    check("reset IReady", IReady, 0);
    check("reset DReady", DReady, 0);
    check("reset IRdata", IRdata, 0);
    check("reset DRdata", DRdata, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // single fetch, zero-wait
    cyc();
    IReq = 1'b1; IAddr = 32'h100;
    iExp.push_back(mkExp(32'hE3A00005, 1'b0, 1'b0));
    cyc();
    check("fetch MemReq", MemReq, 1);
    check("fetch MemAddr", MemAddr, 32'h100);
    manAck = 1'b1; manRdata = 32'hE3A00005; #1;
    check("fetch IReady", IReady, 1);
    check("fetch IRdata", IRdata, 32'hE3A00005);
    check("fetch IStall", IStall, 0);
    cyc();
    IReq = 1'b0; manAck = 1'b0;
    check("fetch MemReq after ack", MemReq, 0);

    // data priority over a simultaneous fetch
    cyc();
    IReq = 1'b1; IAddr = 32'h200; DReq = 1'b1; DWe = 1'b1; DAddr = 32'h40; DWdata = 32'h12345678;
    dExp.push_back(mkExp(32'h0, 1'b1, 1'b0));
    iExp.push_back(mkExp(32'hCAFEF00D, 1'b0, 1'b0));
    cyc();
    check("priority MemReq", MemReq, 1);
    check("priority MemWe", MemWe, 1);
    check("priority MemAddr", MemAddr, 32'h40);
    check("priority MemWdata", MemWdata, 32'h12345678);
    manAck = 1'b1; manRdata = 32'h0; #1;
    check("priority DReady", DReady, 1);
    check("priority IStall", IStall, 1);
    cyc();
    DReq = 1'b0; manAck = 1'b0;
    check("priority idle gap", MemReq, 0);
    cyc();
    check("fetch after data MemReq", MemReq, 1);
    check("fetch after data MemWe", MemWe, 0);
    check("fetch after data MemAddr", MemAddr, 32'h200);
    manAck = 1'b1; manRdata = 32'hCAFEF00D; #1;
    check("fetch after data IReady", IReady, 1);
    cyc();
    IReq = 1'b0; manAck = 1'b0;

    // three wait states on a data read
    cyc();
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h80;
    dExp.push_back(mkExp(32'h0BADCAFE, 1'b0, 1'b0));
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("wait MemReq", MemReq, 1);
      check("wait MemAddr", MemAddr, 32'h80);
      if (k < 4) begin
        #1 check("wait DStall", DStall, 1);
      end else begin
        manAck = 1'b1; manRdata = 32'h0BADCAFE; #1;
        check("wait DStall at ack", DStall, 0);
        check("wait DReady", DReady, 1);
      end
    end
    cyc();
    DReq = 1'b0; manAck = 1'b0; manRdata = 32'hFFFFFFFF; #1;
    check("wait DRdata held", DRdata, 32'h0BADCAFE);

    // starvation: both requesters held high, one wait state per access
    cyc();
    autoMem = 1'b1; fixedWait = 1; noise = 1'b0; chkArb = 1'b1;
    base = grantLog.size();
    fork
      begin
        fetchOp(32'h1000_0010);
        fetchOp(32'h1000_0020);
      end
      begin
        for (int k = 0; k < 8; k++)
          dataOp(1'(k % 2 == 0), 32'h2000_0000 | 32'(k << 2), $urandom);
      end
    join
    cyc();
    chkArb = 1'b0;
    got = '0;
    for (int i = 0; i < 10; i++)
      got = {got[8:0], (base + i < grantLog.size()) ? grantLog[base + i] : 1'b0};
    check("starvation grant count", grantLog.size() - base, 10);
    check("starvation grant order (1=D)", got, 10'b1111011110);

    // watchdog: fetch never acked
    autoMem = 1'b0; manAck = 1'b0;
    cyc();
    IReq = 1'b1; IAddr = 32'h300;
    iExp.push_back(mkExp(32'h0, 1'b0, 1'b1));
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("watchdog MemReq busy", MemReq, 1);
      if (k < 8) begin
        check("watchdog IReady early", IReady, 0);
      end else begin
        check("watchdog IReady pulse", IReady, 1);
        check("watchdog IRdata", IRdata, 32'h0);
      end
    end
    cyc();
    IReq = 1'b0;
    check("watchdog MemReq dropped", MemReq, 0);
    check("watchdog MemErr set", MemErr, 1);
    cyc();
    IReq = 1'b1; IAddr = 32'h304;
    iExp.push_back(mkExp(32'h600D600D, 1'b0, 1'b0));
    cyc();
    check("post-watchdog MemReq", MemReq, 1);
    manAck = 1'b1; manRdata = 32'h600D600D; #1;
    check("post-watchdog IReady", IReady, 1);
    check("post-watchdog IRdata", IRdata, 32'h600D600D);
    cyc();
    IReq = 1'b0; manAck = 1'b0;
    check("MemErr sticky", MemErr, 1);

    // reset in the middle of a data access
    cyc();
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h500;
    cyc();
    check("pre-reset MemReq", MemReq, 1);
    cyc();
    #2 reset = 1'b0;
    #1;
    check("async reset MemReq", MemReq, 0);
    check("async reset MemErr", MemErr, 0);
    check("async reset DReady", DReady, 0);
    check("async reset MemAddr", MemAddr, 0);
    DReq = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    IReq = 1'b1; IAddr = 32'h1000_0400;
    iExp.push_back(mkExp(32'h12121212, 1'b0, 1'b0));
    cyc();
    check("post-reset MemReq", MemReq, 1);
    check("post-reset MemAddr", MemAddr, 32'h1000_0400);
    manAck = 1'b1; manRdata = 32'h12121212; #1;
    check("post-reset IReady", IReady, 1);
    cyc();
    IReq = 1'b0; manAck = 1'b0;

    // randomized traffic with random wait states and stray acks while idle
    cyc();
    autoMem = 1'b1; fixedWait = -1; noise = 1'b1; chkArb = 1'b1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          n = $urandom_range(0, 2);
          repeat (n) cyc();
          fetchOp(32'h1000_0000 | 32'($urandom_range(0, 255) << 2));
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          n = $urandom_range(0, 2);
          repeat (n) cyc();
          dataOp(1'($urandom_range(0, 1)), 32'h2000_0000 | 32'($urandom_range(0, 7) << 2), $urandom);
        end
      end
    join
    repeat (3) cyc();
    chkArb = 1'b0; noise = 1'b0;
    check("fetch scoreboard drained", iExp.size(), 0);
    check("data scoreboard drained", dExp.size(), 0);
    check("final MemErr", MemErr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter. It shares a single unified memory port between the ARM core's instruction-fetch port (PCF/InstrF) and its data port (ALUOutM/WriteDataM/MemWriteM/ReadDataM). It serializes accesses through a small FSM and returns per-port stall signals, which the top level ORs into the hazard unit's StallF/StallD (fetch) and a full-pipe freeze (data). Data accesses have priority, and a starvation counter bounds how long fetch can wait.

## Interface
- STARVE_LIMIT, default 4: max consecutive data grants while fetch waits; must be ≥1.
- TIMEOUT, default 64: cycles an outstanding memory access may wait for MemAck; 0 disables the watchdog.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- IReq  in  1  fetch request; held high until IReady
- IAddr  in  32  fetch address (PCF)
- IRdata  out  32  fetched instruction
- IReady  out  1  fetch completes this cycle
- IStall  out  1  IReq & ~IReady
- DReq  in  1  data request; held high until DReady
- DWe  in  1  1 = write
- DAddr  in  32  data address (ALUOutM)
- DWdata  in  32  write data (WriteDataM)
- DRdata  out  32  load data
- DReady  out  1  data access completes this cycle
- DStall  out  1  DReq & ~DReady
- MemReq  out  1  memory request, registered
- MemWe  out  1  registered
- MemAddr  out  32  registered
- MemWdata  out  32  registered
- MemRdata  in  32  memory read data, valid with MemAck
- MemAck  in  1  memory completes the access this cycle
- MemErr  out  1  sticky watchdog timeout flag

## Operation
- FSM states are IDLE, IBUS and DBUS.
- IDLE:
  - If DReq && !(IReq && scnt==STARVE_LIMIT), go to DBUS. This latches DAddr, DWe and DWdata onto the Mem* outputs and sets MemReq=1.
  - Else if IReq, go to IBUS. This latches IAddr onto MemAddr with MemWe=0 and MemReq=1.
  - Else stay in IDLE.
- IBUS and DBUS:
  - MemReq, MemWe, MemAddr and MemWdata are held stable until MemAck.
  - On MemAck, return to IDLE and clear MemReq.
- Ready outputs are combinational: IReady = (state==IBUS) & MemAck, and DReady = (state==DBUS) & MemAck.
- Read data:
  - IRdata = IReady ? MemRdata : irq, where irq captures MemRdata on IReady.
  - DRdata works the same way for data reads. A data write does not update the captured value.
- Starvation counter scnt:
  - Width is clog2(STARVE_LIMIT+1).
  - Increments on each DBUS grant made while IReq=1.
  - Clears on each IBUS grant, and on any DBUS grant made while IReq=0.
  - Saturates at STARVE_LIMIT.
- Watchdog wcnt:
  - Clears on entry to IBUS or DBUS and increments each busy cycle without MemAck.
  - If TIMEOUT≠0 and wcnt reaches TIMEOUT-1 without an ack:
    - go to IDLE and drop MemReq;
    - pulse the granted port's Ready for one cycle with Rdata=0 (captured register unchanged);
    - set MemErr=1.
  - MemErr stays set until reset.
- A MemAck arriving in IDLE is ignored.
- Requesters are never granted twice back-to-back without passing through IDLE.
- Reset (asynchronous, active-low):
  - State goes to IDLE; MemReq, MemWe, IReady, DReady and MemErr go to 0.
  - MemAddr, MemWdata, captured IRdata/DRdata, scnt and wcnt go to 0.
  - Reset mid-transaction drops MemReq immediately with no Ready pulse.

## Timing
- A request seen in IDLE at cycle N drives MemReq=1 from cycle N+1.
- With zero-wait memory (MemAck at N+1), Ready is high at N+1.
- Throughput is at most one access per 2 cycles.
- A requester may change address or drop Req in the cycle after its Ready. If Req is still high then, it is treated as a new request.
- Simultaneous IReq and DReq in IDLE: data wins unless scnt==STARVE_LIMIT.
- Stall outputs fall in the same cycle as Ready. There is no extra bubble on the core side.
- With a W-wait memory, one access takes W+2 cycles from the request.

## Test plan
- Single fetch, zero-wait: IReq=1, IAddr=0x100 at cycle 0, MemAck=1 with MemRdata=0xE3A00005 at cycle 1.
  - Required: MemReq=1 and MemAddr=0x100 at cycle 1; IReady=1 and IRdata=0xE3A00005 at cycle 1; IStall=0 at cycle 1; MemReq=0 at cycle 2.
- Data priority: IReq=DReq=1 with DWe=1, DAddr=0x40, DWdata=0x12345678.
  - Required: the first grant is a write (MemWe=1, MemAddr=0x40, MemWdata=0x12345678).
  - After DReady, DReq drops; the fetch is granted next.
- Starvation, STARVE_LIMIT=4: IReq and DReq held high continuously, memory acks after 1 cycle.
  - Required grant order: D,D,D,D,I,D,D,D,D,I.
- Wait states: memory acks 3 cycles after MemReq on a data read of 0x80.
  - Required: MemAddr stable for 4 cycles; DStall=1 until the ack cycle; DRdata holds the acked value afterwards.
- Watchdog, TIMEOUT=8: IReq high, no MemAck.
  - Required: MemReq drops after 8 busy cycles; IReady pulses with IRdata=0; MemErr=1 and stays set.
  - A second fetch with an ack still completes.
- Reset: assert reset low mid-DBUS.
  - Required: MemReq=0 and MemErr=0 asynchronously, no DReady pulse.
  - After release, an IDLE grant works normally.
